// File: rtl/sodor5_verif_top.sv
// -----------------------------------------------------------------------------
// sodor5_verif_top
//   Lockstep verification wrapper for a 5-stage (IF/ID/EX/MEM/WB) RV32 integer
//   pipeline that executes R-type ALU instructions only. A single-cycle
//   architectural model executes the same stream. A checker compares every
//   retired write-back against the model.
//
//   Optional feature macro: SODOR5_CHECKER_EN
//     defined   -> architectural model, 3-deep delay line and comparator built
//     undefined -> model omitted, mismatch tied low
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   instr        in   instruction word, sampled every rising edge
//   commit_valid out  WB stage holds a writing (R-type) instruction
//   commit_rd    out  WB destination register
//   commit_data  out  WB result
//   retire_count out  writing instructions retired since reset
//   mismatch     out  sticky flag: pipeline and model disagreed
//
// Neither register file is reset; the bench loads them hierarchically
// (regfile, and model_regfile when the checker is built).
// -----------------------------------------------------------------------------
module sodor5_verif_top #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] instr,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [WORD_SIZE-1:0] commit_data,
  output logic [31:0]          retire_count,
  output logic                 mismatch
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  function automatic logic [WORD_SIZE-1:0] alu(
    input logic [2:0]           f3,
    input logic                 alt,
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b
  );
    logic [4:0] sh;
    sh  = b[4:0];
    alu = '0;
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu[0] = ($signed(a) < $signed(b));
      3'b011:  alu[0] = (a < b);
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? WORD_SIZE'($signed(a) >>> sh) : (a >> sh);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic [WORD_SIZE-1:0] regfile [0:NUM_REGS-1];

  // IF/ID: only the fields the later stages need are kept
  logic                 ifid_valid_q;
  logic [4:0]           ifid_rs1_q, ifid_rs2_q, ifid_rd_q;
  logic [2:0]           ifid_f3_q;
  logic                 ifid_alt_q;

  logic                 idex_valid_q;
  logic [4:0]           idex_rd_q;
  logic [2:0]           idex_f3_q;
  logic                 idex_alt_q;
  logic [WORD_SIZE-1:0] idex_a_q, idex_b_q;

  logic                 exmem_valid_q;
  logic [4:0]           exmem_rd_q;
  logic [WORD_SIZE-1:0] exmem_data_q;

  logic                 memwb_valid_q;
  logic [4:0]           memwb_rd_q;
  logic [WORD_SIZE-1:0] memwb_data_q;

  logic [31:0]          retire_count_q, retire_count_d;

  logic [WORD_SIZE-1:0] id_op_a, id_op_b;
  logic [WORD_SIZE-1:0] ex_result;

  logic                 unused_instr_bits;
  assign unused_instr_bits = ^{instr[WORD_SIZE-1:31], instr[29:25]};

  assign ex_result = alu(idex_f3_q, idex_alt_q, idex_a_q, idex_b_q);

  // Operand read in ID. Later assignments win, so the nearest producer
  // (EX, then MEM, then WB) overrides the register-file value.
  always_comb begin
    id_op_a = (ifid_rs1_q == 5'd0) ? '0 : regfile[ifid_rs1_q];
    id_op_b = (ifid_rs2_q == 5'd0) ? '0 : regfile[ifid_rs2_q];
    if (memwb_valid_q && memwb_rd_q != 5'd0 && memwb_rd_q == ifid_rs1_q) id_op_a = memwb_data_q;
    if (memwb_valid_q && memwb_rd_q != 5'd0 && memwb_rd_q == ifid_rs2_q) id_op_b = memwb_data_q;
    if (exmem_valid_q && exmem_rd_q != 5'd0 && exmem_rd_q == ifid_rs1_q) id_op_a = exmem_data_q;
    if (exmem_valid_q && exmem_rd_q != 5'd0 && exmem_rd_q == ifid_rs2_q) id_op_b = exmem_data_q;
    if (idex_valid_q  && idex_rd_q  != 5'd0 && idex_rd_q  == ifid_rs1_q) id_op_a = ex_result;
    if (idex_valid_q  && idex_rd_q  != 5'd0 && idex_rd_q  == ifid_rs2_q) id_op_b = ex_result;
  end

  assign retire_count_d = memwb_valid_q ? (retire_count_q + 32'd1) : retire_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_q   <= 1'b0;
      ifid_rs1_q     <= '0;
      ifid_rs2_q     <= '0;
      ifid_rd_q      <= '0;
      ifid_f3_q      <= '0;
      ifid_alt_q     <= 1'b0;
      idex_valid_q   <= 1'b0;
      idex_rd_q      <= '0;
      idex_f3_q      <= '0;
      idex_alt_q     <= 1'b0;
      idex_a_q       <= '0;
      idex_b_q       <= '0;
      exmem_valid_q  <= 1'b0;
      exmem_rd_q     <= '0;
      exmem_data_q   <= '0;
      memwb_valid_q  <= 1'b0;
      memwb_rd_q     <= '0;
      memwb_data_q   <= '0;
      retire_count_q <= '0;
    end else begin
      ifid_valid_q   <= (instr[6:0] == OPC_RTYPE);
      ifid_rs1_q     <= instr[19:15];
      ifid_rs2_q     <= instr[24:20];
      ifid_rd_q      <= instr[11:7];
      ifid_f3_q      <= instr[14:12];
      ifid_alt_q     <= instr[30];
      idex_valid_q   <= ifid_valid_q;
      idex_rd_q      <= ifid_rd_q;
      idex_f3_q      <= ifid_f3_q;
      idex_alt_q     <= ifid_alt_q;
      idex_a_q       <= id_op_a;
      idex_b_q       <= id_op_b;
      exmem_valid_q  <= idex_valid_q;
      exmem_rd_q     <= idex_rd_q;
      exmem_data_q   <= ex_result;
      memwb_valid_q  <= exmem_valid_q;
      memwb_rd_q     <= exmem_rd_q;
      memwb_data_q   <= exmem_data_q;
      retire_count_q <= retire_count_d;
    end
  end

  // Write-back; x0 writes retire but are dropped here
  always_ff @(posedge clk) begin
    if (!reset && memwb_valid_q && memwb_rd_q != 5'd0)
      regfile[memwb_rd_q] <= memwb_data_q;
  end

  assign commit_valid = memwb_valid_q;
  assign commit_rd    = memwb_rd_q;
  assign commit_data  = memwb_data_q;
  assign retire_count = retire_count_q;

`ifdef SODOR5_CHECKER_EN
  // Architectural model: executes in the ID cycle from its own register file
  // and updates it at the end of that cycle, so no forwarding is needed.
  logic [WORD_SIZE-1:0] model_regfile [0:NUM_REGS-1];
  logic [WORD_SIZE-1:0] m_a, m_b, m_result;

  // Delay line: index 0 aligns with EX, 1 with MEM, 2 with WB
  logic [2:0]           dl_valid_q;
  logic [4:0]           dl_rd_q   [0:2];
  logic [WORD_SIZE-1:0] dl_data_q [0:2];

  logic                 cmp_fault;
  logic                 mismatch_q, mismatch_d;

  assign m_a      = (ifid_rs1_q == 5'd0) ? '0 : model_regfile[ifid_rs1_q];
  assign m_b      = (ifid_rs2_q == 5'd0) ? '0 : model_regfile[ifid_rs2_q];
  assign m_result = alu(ifid_f3_q, ifid_alt_q, m_a, m_b);

  always_ff @(posedge clk) begin
    if (!reset && ifid_valid_q && ifid_rd_q != 5'd0)
      model_regfile[ifid_rd_q] <= m_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_valid_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        dl_rd_q[i]   <= '0;
        dl_data_q[i] <= '0;
      end
      mismatch_q <= 1'b0;
    end else begin
      dl_valid_q   <= {dl_valid_q[1:0], ifid_valid_q};
      dl_rd_q[0]   <= ifid_rd_q;
      dl_data_q[0] <= m_result;
      dl_rd_q[1]   <= dl_rd_q[0];
      dl_data_q[1] <= dl_data_q[0];
      dl_rd_q[2]   <= dl_rd_q[1];
      dl_data_q[2] <= dl_data_q[1];
      mismatch_q   <= mismatch_d;
    end
  end

  // Fault is visible in the WB cycle itself, then held by mismatch_q
  assign cmp_fault  = (commit_valid || dl_valid_q[2]) &&
                      ((commit_valid != dl_valid_q[2]) ||
                       (commit_rd    != dl_rd_q[2])    ||
                       (commit_data  != dl_data_q[2]));
  assign mismatch_d = mismatch_q | cmp_fault;
  assign mismatch   = mismatch_d;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sodor5_verif_top.sv
// -----------------------------------------------------------------------------
// tb_sodor5_verif_top
//   Directed bench for sodor5_verif_top: reset values, simple add, dependent
//   chain covering EX/MEM/WB bypass, ALU ops and shift/wrap corners, x0
//   handling, a random R-type loop against an ISA reference, checker fault
//   injection (only when SODOR5_CHECKER_EN is defined) and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_sodor5_verif_top;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [31:0] retire_count;
  logic        mismatch;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_retire = 0;

  logic [31:0] ref_rf [0:31];
  logic [31:0] prog   [0:15];

  always #5 clk = ~clk;

  sodor5_verif_top #(.NUM_REGS(32), .WORD_SIZE(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .retire_count (retire_count),
    .mismatch     (mismatch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Loads the same value into the pipeline, model and bench reference
  task automatic setreg(input logic [4:0] idx, input logic [31:0] v);
    dut.regfile[idx] = v;
`ifdef SODOR5_CHECKER_EN
    dut.model_regfile[idx] = v;
`endif
    ref_rf[idx] = v;
  endtask

  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    instr = ins;
  endtask

  // ISA-level reference for the random loop
  task automatic ref_exec(input logic [31:0] ins);
    logic [31:0] a, b, r;
    logic [4:0]  sh;
    if (ins[6:0] == 7'b0110011) begin
      a  = (ins[19:15] == 5'd0) ? 32'd0 : ref_rf[ins[19:15]];
      b  = (ins[24:20] == 5'd0) ? 32'd0 : ref_rf[ins[24:20]];
      sh = b[4:0];
      case (ins[14:12])
        3'd0: r = ins[30] ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
      if (ins[11:7] != 5'd0) ref_rf[ins[11:7]] = r;
      exp_retire++;
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'h00D8_0A33;  // valid instruction held during reset must be ignored
    for (int i = 0; i < 32; i++) setreg(5'(i), (i == 0) ? 32'hDEAD_BEEF : 32'd0);
    repeat (3) @(negedge clk);
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_commit_rd",    {27'd0, commit_rd},    32'd0);
    check("rst_commit_data",  commit_data,           32'd0);
    check("rst_retire",       retire_count,          32'd0);
    check("rst_mismatch",     {31'd0, mismatch},     32'd0);
    instr = NOP;
    reset = 1'b0;

    // Simple add: add x20,x16,x13
    setreg(5'd16, 32'd5);
    setreg(5'd13, 32'd7);
    issue(32'h00D8_0A33);
    exp_retire++;
    repeat (4) issue(NOP);
    check("add_commit_valid", {31'd0, commit_valid}, 32'd1);
    check("add_commit_rd",    {27'd0, commit_rd},    32'd20);
    check("add_commit_data",  commit_data,           32'd12);
    check("add_mismatch",     {31'd0, mismatch},     32'd0);
    issue(NOP);
    check("add_rf20",         dut.regfile[20],       32'd12);
    check("add_valid_after",  {31'd0, commit_valid}, 32'd0);
    check("add_retire",       retire_count,          32'd1);

    // Dependent chain: distance 1 (EX), 2 (MEM), 3 (WB) bypass
    setreg(5'd2, 32'd1);
    setreg(5'd3, 32'd2);
    setreg(5'd1, 32'd100);
    setreg(5'd4, 32'd100);
    setreg(5'd5, 32'd100);
    setreg(5'd6, 32'd100);
    issue(rtype(7'h00, 5'd3, 5'd2, 3'd0, 5'd1));  // add x1,x2,x3
    issue(rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd4));  // add x4,x1,x1
    issue(rtype(7'h00, 5'd1, 5'd4, 3'd0, 5'd5));  // add x5,x4,x1
    issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd6));  // add x6,x1,x0
    exp_retire += 4;
    issue(NOP);
    check("dep1_rd",   {27'd0, commit_rd}, 32'd1);
    check("dep1_data", commit_data,        32'd3);
    issue(NOP);
    check("dep2_rd",   {27'd0, commit_rd}, 32'd4);
    check("dep2_data", commit_data,        32'd6);
    issue(NOP);
    check("dep3_rd",   {27'd0, commit_rd}, 32'd5);
    check("dep3_data", commit_data,        32'd9);
    issue(NOP);
    check("dep4_rd",   {27'd0, commit_rd}, 32'd6);
    check("dep4_data", commit_data,        32'd3);
    issue(NOP);
    check("dep_rf5",    dut.regfile[5], 32'd9);
    check("dep_rf6",    dut.regfile[6], 32'd3);
    check("dep_retire", retire_count,   32'd5);

    // ALU ops, signed/unsigned compares, shift amount from rs2[4:0], wrap
    setreg(5'd1,  32'hFFFF_FFFF);
    setreg(5'd2,  32'd1);
    setreg(5'd12, 32'h0000_0021);
    for (int i = 3; i <= 15; i++) if (i != 12) setreg(5'(i), 32'h5A5A_5A5A);
    issue(rtype(7'h00, 5'd1,  5'd2, 3'd3, 5'd3));   // sltu x3,x2,x1
    issue(rtype(7'h20, 5'd1,  5'd2, 3'd0, 5'd4));   // sub  x4,x2,x1
    issue(rtype(7'h00, 5'd1,  5'd2, 3'd2, 5'd5));   // slt  x5,x2,x1
    issue(rtype(7'h20, 5'd2,  5'd1, 3'd5, 5'd6));   // sra  x6,x1,x2
    issue(rtype(7'h00, 5'd2,  5'd1, 3'd5, 5'd7));   // srl  x7,x1,x2
    issue(rtype(7'h00, 5'd2,  5'd1, 3'd1, 5'd8));   // sll  x8,x1,x2
    issue(rtype(7'h00, 5'd2,  5'd1, 3'd4, 5'd9));   // xor  x9,x1,x2
    issue(rtype(7'h00, 5'd12, 5'd2, 3'd6, 5'd10));  // or   x10,x2,x12
    issue(rtype(7'h00, 5'd12, 5'd1, 3'd7, 5'd11));  // and  x11,x1,x12
    issue(rtype(7'h00, 5'd12, 5'd2, 3'd1, 5'd13));  // sll  x13,x2,x12
    issue(rtype(7'h00, 5'd2,  5'd1, 3'd0, 5'd14));  // add  x14,x1,x2
    issue(rtype(7'h00, 5'd2,  5'd1, 3'd2, 5'd15));  // slt  x15,x1,x2
    exp_retire += 12;
    repeat (5) issue(NOP);
    check("sltu_x3", dut.regfile[3],  32'd1);
    check("sub_x4",  dut.regfile[4],  32'd2);
    check("slt_x5",  dut.regfile[5],  32'd0);
    check("sra_x6",  dut.regfile[6],  32'hFFFF_FFFF);
    check("srl_x7",  dut.regfile[7],  32'h7FFF_FFFF);
    check("sll_x8",  dut.regfile[8],  32'hFFFF_FFFE);
    check("xor_x9",  dut.regfile[9],  32'hFFFF_FFFE);
    check("or_x10",  dut.regfile[10], 32'h0000_0021);
    check("and_x11", dut.regfile[11], 32'h0000_0021);
    check("shamt_x13", dut.regfile[13], 32'd2);
    check("wrap_x14",  dut.regfile[14], 32'd0);
    check("slt_neg_x15", dut.regfile[15], 32'd1);
    check("alu_retire", retire_count, 32'd17);

    // x0 handling
    setreg(5'd3, 32'd4);
    setreg(5'd1, 32'd5);
    setreg(5'd5, 32'h1234_5678);
    issue(32'h0011_8033);                          // add x0,x3,x1
    issue(rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd5));   // add x5,x0,x0
    exp_retire += 2;
    repeat (3) issue(NOP);
    check("x0_commit_valid", {31'd0, commit_valid}, 32'd1);
    check("x0_commit_rd",    {27'd0, commit_rd},    32'd0);
    check("x0_commit_data",  commit_data,           32'd9);
    issue(NOP);
    check("x0src_commit_rd",   {27'd0, commit_rd}, 32'd5);
    check("x0src_commit_data", commit_data,        32'd0);
    issue(NOP);
    check("x0_rf5",     dut.regfile[5], 32'd0);
    check("x0_rf0",     dut.regfile[0], 32'hDEAD_BEEF);
    check("x0_retire",  retire_count,   32'd19);

    // Random 16-instruction loop for 100 cycles
    for (int i = 1; i < 32; i++) setreg(5'(i), $urandom);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(7) == 0)
        prog[k] = ($urandom_range(1) == 0) ? NOP : 32'h0000_0000;
      else
        prog[k] = rtype({1'b0, 1'($urandom_range(1)), 5'd0}, 5'($urandom_range(31)),
                        5'($urandom_range(31)), 3'($urandom_range(7)), 5'($urandom_range(31)));
    end
    for (int c = 0; c < 100; c++) begin
      ref_exec(prog[c % 16]);
      issue(prog[c % 16]);
    end
    repeat (5) issue(NOP);
    check("rand_mismatch", {31'd0, mismatch}, 32'd0);
    check("rand_retire",   retire_count,      exp_retire);
    for (int i = 1; i < 32; i++) check($sformatf("rand_rf%0d", i), dut.regfile[i], ref_rf[i]);
    check("rand_rf0", dut.regfile[0], 32'hDEAD_BEEF);

`ifdef SODOR5_CHECKER_EN
    // Fault injection: model copy of x2 corrupted before the consumer reads it
    setreg(5'd1, 32'd10);
    setreg(5'd2, 32'd20);
    setreg(5'd3, 32'd0);
    dut.model_regfile[2] = 32'd21;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));   // add x3,x1,x2
    exp_retire++;
    repeat (3) issue(NOP);
    check("fault_pre_wb", {31'd0, mismatch}, 32'd0);
    issue(NOP);
    check("fault_wb",        {31'd0, mismatch}, 32'd1);
    check("fault_pipe_data", commit_data,       32'd30);
    repeat (2) issue(NOP);
    check("fault_sticky",    {31'd0, mismatch}, 32'd1);
`endif

    // Mid-stream asynchronous reset discards in-flight work
    check("pre_reset_retire", retire_count, exp_retire);
    setreg(5'd1, 32'd10);
    setreg(5'd2, 32'd20);
    setreg(5'd7, 32'h77);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd7));   // add x7,x1,x2
    issue(NOP);
    #2 reset = 1'b1;
    #1;
    check("arst_mismatch",     {31'd0, mismatch},     32'd0);
    check("arst_retire",       retire_count,          32'd0);
    check("arst_commit_valid", {31'd0, commit_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) issue(NOP);
    check("arst_rf7_kept",    dut.regfile[7], 32'h77);
    check("arst_retire_hold", retire_count,   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
